// File: rtl/multicycle_ctrl_v2_if.sv
// Control bundle between the multi-cycle controller and the datapath.
// The master side is the controller: it consumes IR fields and status,
// and drives the datapath strobes and mux selects.
interface multicycle_ctrl_v2_if;
    // IR fields and datapath/memory status
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       branch_taken;
    logic       mem_ready;
    // Strobes and mux selects
    logic       pc_en;
    logic [1:0] pc_src;
    logic       ir_en;
    logic       regfile_we;
    logic [1:0] wb_sel;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       illegal;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, funct3, funct7_5, branch_taken, mem_ready,
        output pc_en, pc_src, ir_en, regfile_we, wb_sel, alu_src_a, alu_src_b,
               alu_op, mem_read, mem_write, illegal, state_dbg
    );

    modport slave (
        output opcode, funct3, funct7_5, branch_taken, mem_ready,
        input  pc_en, pc_src, ir_en, regfile_we, wb_sel, alu_src_a, alu_src_b,
               alu_op, mem_read, mem_write, illegal, state_dbg
    );
endinterface

// File: rtl/multicycle_ctrl_v2.sv
// Multi-cycle RV32I controller FSM. Decodes the base opcode set, derives
// the ALU op, sequences fetch/decode/execute/mem/writeback, and optionally
// traps on illegal opcodes. Outputs are combinational from state + inputs.
module multicycle_ctrl_v2 #(
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    multicycle_ctrl_v2_if.master bus
);
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_EXECUTE   = 4'd2;
    localparam logic [3:0] S_MEM       = 4'd3;
    localparam logic [3:0] S_WRITEBACK = 4'd4;
    localparam logic [3:0] S_BRANCH    = 4'd5;
    localparam logic [3:0] S_JUMP      = 4'd6;
    localparam logic [3:0] S_TRAP      = 4'd7;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    logic [3:0] state_q, state_d;

    logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
    logic ready;

    logic       pc_en_c, ir_en_c, we_c, mrd_c, mwr_c, ill_c;
    logic [1:0] pc_src_c, wb_sel_c, src_a_c, src_b_c;
    logic [3:0] alu_op_c;

    assign is_r     = (bus.opcode == OP_R);
    assign is_i     = (bus.opcode == OP_I);
    assign is_ld    = (bus.opcode == OP_LOAD);
    assign is_st    = (bus.opcode == OP_STORE);
    assign is_br    = (bus.opcode == OP_BRANCH);
    assign is_jal   = (bus.opcode == OP_JAL);
    assign is_jalr  = (bus.opcode == OP_JALR);
    assign is_lui   = (bus.opcode == OP_LUI);
    assign is_auipc = (bus.opcode == OP_AUIPC);

    // Without the handshake every memory access is treated as single-cycle.
    assign ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    // State register; reset aborts any in-flight instruction.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= S_FETCH;
        else         state_q <= state_d;
    end

    // Next-state and control decode; unlisted outputs stay 0.
    always_comb begin
        state_d  = state_q;
        pc_en_c  = 1'b0;
        pc_src_c = 2'd0;
        ir_en_c  = 1'b0;
        we_c     = 1'b0;
        wb_sel_c = 2'd0;
        src_a_c  = 2'd0;
        src_b_c  = 2'd0;
        alu_op_c = ALU_ADD;
        mrd_c    = 1'b0;
        mwr_c    = 1'b0;
        ill_c    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mrd_c = 1'b1;
                if (ready) begin
                    ir_en_c = 1'b1;
                    pc_en_c = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute old_pc + imm so BRANCH/JAL find their target in ALUOut.
                src_a_c = 2'd0;
                src_b_c = 2'd2;
                if (is_r || is_i || is_ld || is_st || is_lui || is_auipc)
                    state_d = S_EXECUTE;
                else if (is_br)
                    state_d = S_BRANCH;
                else if (is_jal || is_jalr)
                    state_d = S_JUMP;
                else
                    state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
            end
            S_EXECUTE: begin
                if (is_r) begin
                    src_a_c  = 2'd1;
                    src_b_c  = 2'd1;
                    alu_op_c = {bus.funct7_5, bus.funct3};
                end else if (is_i) begin
                    // IR[30] is immediate data except for SRAI.
                    src_a_c  = 2'd1;
                    src_b_c  = 2'd2;
                    alu_op_c = {bus.funct7_5 & (bus.funct3 == 3'b101), bus.funct3};
                end else if (is_ld || is_st) begin
                    src_a_c = 2'd1;
                    src_b_c = 2'd2;
                end else if (is_lui) begin
                    src_a_c = 2'd2;
                    src_b_c = 2'd2;
                end else begin
                    src_a_c = 2'd0;
                    src_b_c = 2'd2;
                end
                state_d = (is_ld || is_st) ? S_MEM : S_WRITEBACK;
            end
            S_MEM: begin
                // Request held steady until the memory acknowledges.
                mrd_c = is_ld;
                mwr_c = is_st;
                if (ready) state_d = is_ld ? S_WRITEBACK : S_FETCH;
            end
            S_WRITEBACK: begin
                we_c     = 1'b1;
                wb_sel_c = is_ld ? 2'd1 : 2'd0;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                src_a_c  = 2'd1;
                src_b_c  = 2'd1;
                alu_op_c = ALU_SUB;
                if (bus.branch_taken) begin
                    pc_en_c  = 1'b1;
                    pc_src_c = 2'd1;
                end
                state_d = S_FETCH;
            end
            S_JUMP: begin
                we_c     = 1'b1;
                wb_sel_c = 2'd2;
                pc_en_c  = 1'b1;
                if (is_jalr) begin
                    // JALR target is rs1 + imm straight from the ALU.
                    pc_src_c = 2'd2;
                    src_a_c  = 2'd1;
                    src_b_c  = 2'd2;
                end else begin
                    pc_src_c = 2'd1;
                end
                state_d = S_FETCH;
            end
            S_TRAP: begin
                ill_c = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // All outputs forced low while reset is held.
    assign bus.pc_en      = pc_en_c & ~reset_i;
    assign bus.pc_src     = reset_i ? 2'd0 : pc_src_c;
    assign bus.ir_en      = ir_en_c & ~reset_i;
    assign bus.regfile_we = we_c & ~reset_i;
    assign bus.wb_sel     = reset_i ? 2'd0 : wb_sel_c;
    assign bus.alu_src_a  = reset_i ? 2'd0 : src_a_c;
    assign bus.alu_src_b  = reset_i ? 2'd0 : src_b_c;
    assign bus.alu_op     = reset_i ? 4'd0 : alu_op_c;
    assign bus.mem_read   = mrd_c & ~reset_i;
    assign bus.mem_write  = mwr_c & ~reset_i;
    assign bus.illegal    = ill_c & ~reset_i;
    assign bus.state_dbg  = reset_i ? S_FETCH : state_q;
endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Directed bench: DUT A uses handshake + trap, DUT B neither. Both share
// stimulus; each test resets and then runs one instruction on one DUT.
module tb_multicycle_ctrl_v2;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'b0100011;
    logic [2:0] funct3 = 3'd0;
    logic       funct7_5 = 1'b0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b1;

    always #5 clk = ~clk;

    multicycle_ctrl_v2_if ifa ();
    multicycle_ctrl_v2_if ifb ();

    assign ifa.opcode = opcode;       assign ifb.opcode = opcode;
    assign ifa.funct3 = funct3;       assign ifb.funct3 = funct3;
    assign ifa.funct7_5 = funct7_5;   assign ifb.funct7_5 = funct7_5;
    assign ifa.branch_taken = branch_taken; assign ifb.branch_taken = branch_taken;
    assign ifa.mem_ready = mem_ready; assign ifb.mem_ready = mem_ready;

    multicycle_ctrl_v2 #(.MEM_HANDSHAKE(1'b1), .TRAP_ON_ILLEGAL(1'b1)) dut_a (
        .clk_i(clk), .reset_i(reset), .bus(ifa.master));
    multicycle_ctrl_v2 #(.MEM_HANDSHAKE(1'b0), .TRAP_ON_ILLEGAL(1'b0)) dut_b (
        .clk_i(clk), .reset_i(reset), .bus(ifb.master));

    typedef struct packed {
        logic       pc_en;
        logic [1:0] pc_src;
        logic       ir_en;
        logic       we;
        logic [1:0] wb_sel;
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] alu_op;
        logic       mrd;
        logic       mwr;
        logic       ill;
        logic [3:0] st;
    } snap_t;

    int tests = 0;
    int fails = 0;

    snap_t ss [8];
    int cyc, n_pcen, n_we, n_mrd_mem, n_both;

    function automatic snap_t cur(input bit sel);
        snap_t s;
        if (sel) s = '{ifb.pc_en, ifb.pc_src, ifb.ir_en, ifb.regfile_we, ifb.wb_sel,
                       ifb.alu_src_a, ifb.alu_src_b, ifb.alu_op, ifb.mem_read,
                       ifb.mem_write, ifb.illegal, ifb.state_dbg};
        else     s = '{ifa.pc_en, ifa.pc_src, ifa.ir_en, ifa.regfile_we, ifa.wb_sel,
                       ifa.alu_src_a, ifa.alu_src_b, ifa.alu_op, ifa.mem_read,
                       ifa.mem_write, ifa.illegal, ifa.state_dbg};
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold reset two edges, release just after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Runs one instruction from FETCH on the selected DUT, logging the last
    // snapshot seen in each state. Stops on return to FETCH or entry to TRAP.
    task automatic run_instr(input bit sel, input logic [6:0] op, input logic [2:0] f3,
                             input logic f75, input logic bt, input int low_mem);
        snap_t s;
        int low = low_mem;
        bit done = 1'b0;
        opcode = op; funct3 = f3; funct7_5 = f75; branch_taken = bt;
        cyc = 0; n_pcen = 0; n_we = 0; n_mrd_mem = 0; n_both = 0;
        for (int k = 0; k < 40; k++) begin
            s = cur(sel);
            if (s.st == 4'd3 && low > 0) begin
                mem_ready = 1'b0;
                low--;
            end else begin
                mem_ready = 1'b1;
            end
            @(negedge clk);
            s = cur(sel);
            ss[s.st[2:0]] = s;
            cyc++;
            n_pcen += int'(s.pc_en);
            n_we += int'(s.we);
            if (s.st == 4'd3 && s.mrd) n_mrd_mem++;
            if (s.mrd && s.mwr) n_both++;
            @(posedge clk); #1;
            s = cur(sel);
            if (s.st == 4'd0 || s.st == 4'd7) begin
                done = 1'b1;
                break;
            end
        end
        mem_ready = 1'b1;
        chk("run_done", 32'(done), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        snap_t e;
        int bad;

        // Reset: every output low on both DUTs
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("reset_a", 32'(cur(0)), 32'd0);
        chk("reset_b", 32'(cur(1)), 32'd0);

        // ADD
        do_reset();
        run_instr(0, 7'b0110011, 3'b000, 1'b0, 1'b0, 0);
        chk("add_cyc", cyc, 4);
        chk("add_fetch_ir", 32'(ss[0].ir_en), 1);
        chk("dec_a", 32'(ss[1].a), 0);
        chk("dec_b", 32'(ss[1].b), 2);
        chk("add_alu", 32'(ss[2].alu_op), 4'b0000);
        chk("add_ab", 32'({ss[2].a, ss[2].b}), 4'b0101);
        chk("add_wb_we", 32'(ss[4].we), 1);
        chk("add_wb_sel", 32'(ss[4].wb_sel), 0);
        chk("add_pcen", n_pcen, 1);

        // SUB
        do_reset();
        run_instr(0, 7'b0110011, 3'b000, 1'b1, 1'b0, 0);
        chk("sub_cyc", cyc, 4);
        chk("sub_alu", 32'(ss[2].alu_op), 4'b1000);

        // ADDI with IR[30]=1 stays ADD; SRAI keeps its bit
        do_reset();
        run_instr(0, 7'b0010011, 3'b000, 1'b1, 1'b0, 0);
        chk("addi_alu", 32'(ss[2].alu_op), 4'b0000);
        chk("addi_b", 32'(ss[2].b), 2);
        do_reset();
        run_instr(0, 7'b0010011, 3'b101, 1'b1, 1'b0, 0);
        chk("srai_alu", 32'(ss[2].alu_op), 4'b1101);

        // LUI / AUIPC operand selects
        do_reset();
        run_instr(0, 7'b0110111, 3'b000, 1'b0, 1'b0, 0);
        chk("lui_cyc", cyc, 4);
        chk("lui_ab", 32'({ss[2].a, ss[2].b}), 4'b1010);
        do_reset();
        run_instr(0, 7'b0010111, 3'b000, 1'b0, 1'b0, 0);
        chk("auipc_ab", 32'({ss[2].a, ss[2].b}), 4'b0010);

        // LOAD with 3 wait cycles (handshake on), then same on DUT B
        do_reset();
        run_instr(0, 7'b0000011, 3'b010, 1'b0, 1'b0, 3);
        chk("ld_cyc", cyc, 8);
        chk("ld_mrd_mem", n_mrd_mem, 4);
        chk("ld_wb_sel", 32'(ss[4].wb_sel), 1);
        chk("ld_both", n_both, 0);
        do_reset();
        run_instr(1, 7'b0000011, 3'b010, 1'b0, 1'b0, 3);
        chk("ld_nohs_cyc", cyc, 5);

        // STORE
        do_reset();
        run_instr(0, 7'b0100011, 3'b010, 1'b0, 1'b0, 0);
        chk("st_cyc", cyc, 4);
        chk("st_we", n_we, 0);
        chk("st_mem", 32'({ss[3].mrd, ss[3].mwr}), 2'b01);

        // BEQ taken / not taken
        do_reset();
        run_instr(0, 7'b1100011, 3'b000, 1'b0, 1'b1, 0);
        chk("beq_t_cyc", cyc, 3);
        chk("beq_t_pc", 32'({ss[5].pc_en, ss[5].pc_src}), 3'b101);
        chk("beq_t_alu", 32'(ss[5].alu_op), 4'b1000);
        chk("beq_t_pcen", n_pcen, 2);
        chk("beq_t_we", n_we, 0);
        do_reset();
        run_instr(0, 7'b1100011, 3'b000, 1'b0, 1'b0, 0);
        chk("beq_n_cyc", cyc, 3);
        chk("beq_n_pcen", 32'(ss[5].pc_en), 0);

        // JALR / JAL
        do_reset();
        run_instr(0, 7'b1100111, 3'b000, 1'b0, 1'b0, 0);
        chk("jalr_cyc", cyc, 3);
        chk("jalr_wb", 32'({ss[6].we, ss[6].wb_sel}), 3'b110);
        chk("jalr_pc", 32'({ss[6].pc_en, ss[6].pc_src}), 3'b110);
        chk("jalr_ab", 32'({ss[6].a, ss[6].b}), 4'b0110);
        chk("jalr_pcen", n_pcen, 2);
        do_reset();
        run_instr(0, 7'b1101111, 3'b000, 1'b0, 1'b0, 0);
        chk("jal_cyc", cyc, 3);
        chk("jal_src", 32'(ss[6].pc_src), 1);

        // Illegal opcode, trapping DUT: sticky until reset
        do_reset();
        run_instr(0, 7'b0000000, 3'b000, 1'b0, 1'b0, 0);
        chk("trap_entry_cyc", cyc, 2);
        e = '0; e.ill = 1'b1; e.st = 4'd7;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cur(0) !== e) bad++;
        end
        chk("trap_hold", bad, 0);
        reset = 1'b1;
        #1;
        chk("trap_rst_ill", 32'(cur(0).ill), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("trap_post_st", 32'(cur(0).st), 0);

        // Illegal opcode, non-trapping DUT: back to FETCH after DECODE
        do_reset();
        run_instr(1, 7'b0000000, 3'b000, 1'b0, 1'b0, 0);
        chk("nop_cyc", cyc, 2);
        chk("nop_state", 32'(cur(1).st), 0);

        // Reset during MEM of a STORE
        do_reset();
        opcode = 7'b0100011; funct3 = 3'b010; funct7_5 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("strst_in_mem", 32'({cur(0).st, cur(0).mwr}), 5'b00111);
        #1 reset = 1'b1;
        #1;
        chk("strst_drop", 32'({cur(0).st, cur(0).mwr}), 5'b00000);
        @(posedge clk); #1;
        reset = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("strst_fetch", 32'({cur(0).st, cur(0).mrd, cur(0).mwr}), 6'b000010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl_v2.md
Name: multicycle_ctrl_v2

Overview:
- Parametrised next-generation FSM controller for the multi-cycle RV32I core.
- Decodes the full RV32I base opcode set: R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
- Derives a 4-bit ALU op from funct3/funct7[5], accepts an external branch_taken, and supports a memory ready handshake.
- Sits between the instruction register and the datapath muxes, register file and unified memory port; handles illegal opcodes with a configurable trap.

Parameters:
- MEM_HANDSHAKE, 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored, every access completes in one cycle.
- TRAP_ON_ILLEGAL, 1: 1 = illegal opcode enters TRAP (sticky); 0 = illegal opcode returns to FETCH (NOP).

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high; state -> FETCH
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- branch_taken  in  1  datapath comparator result for current funct3, valid in BRANCH
- mem_ready  in  1  memory access complete this cycle
- pc_en  out  1  PC load strobe
- pc_src  out  2  0 = PC+4, 1 = ALUOut (latched target), 2 = live ALU result (JALR)
- ir_en  out  1  IR and old_pc load strobe
- regfile_we  out  1  rd write enable
- wb_sel  out  2  0 = ALUOut, 1 = memory data register, 2 = old_pc+4 (link)
- alu_src_a  out  2  0 = old_pc, 1 = rs1, 2 = zero
- alu_src_b  out  2  0 = const 4, 1 = rs2, 2 = immediate
- alu_op  out  4  0000 = ADD, 1000 = SUB, otherwise {f7_5, funct3}
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- illegal  out  1  high while in TRAP
- state_dbg  out  4  current state encoding

Behaviour:
- States: FETCH = 0, DECODE = 1, EXECUTE = 2, MEM = 3, WRITEBACK = 4, BRANCH = 5, JUMP = 6, TRAP = 7. Outputs are Moore/Mealy combinational from state plus inputs; unlisted outputs are 0.
- Reset: while reset is high, all outputs are forced to 0 and state = FETCH. The first fetch occurs on the first cycle after deassert. Reset mid-instruction aborts the instruction and no write strobes are issued.
- ready = mem_ready when MEM_HANDSHAKE = 1, else 1.
- FETCH: mem_read = 1.
  - If ready: ir_en = 1, pc_en = 1, pc_src = 0 -> DECODE.
  - Else: hold in FETCH, pc_en = ir_en = 0.
- DECODE: alu_src_a = 0, alu_src_b = 2, alu_op = ADD (ALUOut <= old_pc + imm, the branch/JAL target). Next state:
  - R/I-ALU/LOAD/STORE/LUI/AUIPC -> EXECUTE
  - BRANCH -> BRANCH
  - JAL/JALR -> JUMP
  - other opcodes -> TRAP if TRAP_ON_ILLEGAL, else FETCH
- EXECUTE:
  - R: a = 1, b = 1, alu_op = {funct7_5, funct3}.
  - I-ALU: a = 1, b = 2, alu_op = {funct7_5 & (funct3 == 3'b101), funct3}. SRAI is preserved; ADDI never becomes SUB.
  - LOAD/STORE: a = 1, b = 2, ADD -> MEM.
  - LUI: a = 2, b = 2, ADD.
  - AUIPC: a = 0, b = 2, ADD.
  - Non-memory instructions -> WRITEBACK.
- MEM:
  - LOAD: mem_read = 1.
  - STORE: mem_write = 1.
  - Held until ready; then LOAD -> WRITEBACK, STORE -> FETCH.
  - Requests stay asserted and stable across wait cycles.
- WRITEBACK: regfile_we = 1, wb_sel = 1 for LOAD, else 0 -> FETCH. Exactly one cycle.
- BRANCH: a = 1, b = 1, alu_op = SUB. If branch_taken: pc_en = 1, pc_src = 1. Always -> FETCH; not-taken leaves PC = old_pc + 4.
- JUMP: regfile_we = 1, wb_sel = 2, pc_en = 1.
  - JAL: pc_src = 1.
  - JALR: pc_src = 2, a = 1, b = 2, ADD.
  - -> FETCH.
- TRAP: illegal = 1, all strobes 0. Stays until reset.
- Cycle counts with ready always 1: R/I/LUI/AUIPC 4, LOAD 5, STORE 4, BRANCH 3, JAL/JALR 3. Each ready-low cycle in FETCH/MEM adds 1.
- Invariants:
  - pc_en is asserted at most twice per instruction (FETCH, plus BRANCH-taken or JUMP).
  - mem_read and mem_write are never both 1.
  - regfile_we is never 1 for STORE or BRANCH.

Test Plan:
- ADD (0110011, f3 = 000, f7_5 = 0), then SUB (f7_5 = 1), mem_ready = 1 -> 4 cycles each; EXECUTE alu_op = 0000 then 1000; WRITEBACK regfile_we = 1, wb_sel = 0.
- ADDI with IR[30] = 1 vs SRAI (f3 = 101, IR[30] = 1) -> alu_op 0000 vs 1101.
- LOAD with mem_ready low for 3 cycles in MEM -> mem_read held 4 cycles, total 8 cycles, wb_sel = 1. With MEM_HANDSHAKE = 0 the same stimulus takes 5 cycles.
- BEQ with branch_taken = 1 -> BRANCH pc_en = 1, pc_src = 1. With branch_taken = 0 -> pc_en = 0 in BRANCH. 3 cycles both.
- JALR -> JUMP: regfile_we = 1, wb_sel = 2, pc_src = 2, alu_src_a = 1, alu_src_b = 2.
- opcode 0000000 -> TRAP_ON_ILLEGAL = 1: illegal = 1 and state_dbg = 7 held 20 cycles, cleared by reset. TRAP_ON_ILLEGAL = 0: back to FETCH after DECODE. Reset asserted in MEM of a STORE -> mem_write drops immediately, next post-reset state is FETCH.
